fetch_arbiter: RTL and testbench
================================

# fetch_arbiter

Round-robin arbiter that shares `NUM_CHANNELS` instruction-memory read channels among `NUM_CONSUMERS` fetchers (one per warp across all cores). It sits between the compute cores' fetcher ports and the top-level instruction-memory ports. It replaces the direct one-warp-per-channel wiring, so the warp count no longer dictates the memory channel count. Each channel runs an independent three-state FSM; a single rotating priority pointer guarantees starvation freedom.

## Interface
- `NUM_CONSUMERS`, default 4: number of fetcher requesters; must be ≥1.
- `NUM_CHANNELS`, default 1: number of instruction-memory channels; must be ≥1 and ≤`NUM_CONSUMERS`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `consumer_read_valid` in [NUM_CONSUMERS]: fetch request, held high until the matching ready pulse.
- `consumer_read_address` in instruction_memory_address_t ×NUM_CONSUMERS: must be stable while valid is high.
- `consumer_read_ready` out [NUM_CONSUMERS]: one-cycle pulse; data is valid in the same cycle.
- `consumer_read_data` out instruction_t ×NUM_CONSUMERS: returned instruction, registered.
- `mem_read_valid` out [NUM_CHANNELS]: channel request to memory, held until `mem_read_ready`.
- `mem_read_address` out instruction_memory_address_t ×NUM_CHANNELS: registered at grant.
- `mem_read_ready` in [NUM_CHANNELS]: memory response strobe; data is valid in the same cycle.
- `mem_read_data` in instruction_t ×NUM_CHANNELS: memory response data.
- `busy` out 1: OR over channels of (state ≠ IDLE). Combinational from state.

## Operation
- Per-channel states:
  - IDLE: no transaction.
  - WAITING: request outstanding to memory.
  - RELAY: one cycle driving `consumer_read_ready` to the owner.
- Per-channel registers: `owner` (clog2(NUM_CONSUMERS) bits) and `mem_read_address`.
- **Eligibility:** a consumer is eligible when its valid is high and it is not the `owner` of any channel in WAITING or RELAY.
- **Grant order:**
  - Channels in IDLE are evaluated in ascending channel index within one cycle.
  - Channel k scans consumers from `rr_ptr` upward, modulo NUM_CONSUMERS.
  - Channel k takes the first eligible consumer not already granted to a lower channel that cycle.
- **On grant:**
  - `owner` ← consumer index.
  - `mem_read_address[k]` ← that consumer's address.
  - State → WAITING.
- **Pointer update:** `rr_ptr` ← (index granted by the highest-numbered granting channel + 1) mod NUM_CONSUMERS. If nothing is granted, `rr_ptr` is unchanged. Modulo wrap applies for non-power-of-two NUM_CONSUMERS.
- **WAITING:**
  - `mem_read_valid[k]` = 1.
  - On `mem_read_ready[k]`: `consumer_read_data[owner]` ← `mem_read_data[k]`, state → RELAY.
- **RELAY:**
  - `consumer_read_ready[owner]` = 1 for exactly this cycle.
  - State → IDLE.
- **Consumer protocol:** the consumer drops valid on the edge after sampling ready. Otherwise the held valid is treated as a new request.
- **Protocol violations:**
  - A consumer dropping valid during WAITING is ignored; the transaction completes and the ready pulse is still issued.
  - An address change during WAITING is ignored; the latched address is used.
- `consumer_read_data[i]` holds its last value until overwritten.

## Timing
- Reset values:
  - All channels IDLE, `owner` = 0, `rr_ptr` = 0.
  - `mem_read_valid` = 0, `mem_read_address` = 0.
  - `consumer_read_ready` = 0, `consumer_read_data` = 0, `busy` = 0.
- Reset mid-transaction aborts immediately: `mem_read_valid` is low on the cycle after the reset edge, and no ready pulse is issued. Memory must tolerate a withdrawn request.
- Latency, with valid first seen in IDLE at cycle c:
  - `mem_read_valid` is high at c+1.
  - If `mem_read_ready` is seen at cycle m ≥ c+1, `consumer_read_ready` pulses at m+1.
  - Minimum request-to-ready latency is 2 cycles.
- Channel turnaround: RELAY→IDLE→next grant. A channel issues at most one new request every 3 cycles at zero memory latency.
- The same consumer is re-grantable in the first IDLE cycle after its RELAY.
- `mem_read_ready` while a channel is IDLE or RELAY is ignored.
- Simultaneous grant on one channel and RELAY on another in the same cycle is legal.

## Test plan
- **Single request:** NUM_CONSUMERS=4, NUM_CHANNELS=1; consumer 2 requests address 0x10, memory returns 0xDEADBEEF with 0 wait → `mem_read_valid` high at c+1 with address 0x10, `consumer_read_ready[2]` pulse at c+2 with data 0xDEADBEEF.
- **Round-robin fairness:** all 4 consumers request continuously with 1 channel → grant order 0,1,2,3,0.
- **Starvation check:** consumer 0 re-requests immediately after each ready while consumer 3 waits → consumer 3 is served within 4 grants.
- **Dual-channel concurrency:** NUM_CHANNELS=2, consumers 1 and 3 valid in the same cycle → channel 0 gets 1, channel 1 gets 3 in the same cycle, `rr_ptr`=0 afterwards; no consumer is granted twice.
- **Memory stall:** `mem_read_ready` delayed 5 cycles → `mem_read_valid` and address stay stable for 6 cycles, `busy`=1 throughout, exactly one ready pulse.
- **Reset mid-WAITING:** assert reset in WAITING → next cycle all outputs are at reset values and no ready pulse appears; a fresh request after reset completes normally.

Source files
------------

// File: rtl/fetch_arbiter.sv
// Round-robin arbiter sharing instruction-memory read channels among fetchers.
// Each channel runs IDLE -> WAITING -> RELAY; one rotating pointer orders grants.
module fetch_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] consumer_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  mem_read_data,
  output logic                                     busy
);

  localparam int OW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef logic [OW-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, WAITING, RELAY} state_e;

  state_e state_q [NUM_CHANNELS];
  state_e state_d [NUM_CHANNELS];
  idx_t   owner_q [NUM_CHANNELS];
  idx_t   owner_d [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] data_q, data_d;
  idx_t                                     rr_q, rr_d;

  logic [NUM_CONSUMERS-1:0] taken;
  logic                     found;
  idx_t                     pick;
  idx_t                     cand;

  function automatic idx_t wrap_add(input idx_t base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CONSUMERS) s = s - NUM_CONSUMERS;
    return idx_t'(s);
  endfunction

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rr_d    = rr_q;
    taken   = '0;
    found   = 1'b0;
    pick    = '0;
    cand    = '0;

    // Owners of busy channels are ineligible for a second grant.
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (state_q[k] != IDLE) taken[owner_q[k]] = 1'b1;
    end

    for (int k = 0; k < NUM_CHANNELS; k++) begin
      unique case (state_q[k])
        IDLE: begin
          found = 1'b0;
          pick  = '0;
          for (int j = 0; j < NUM_CONSUMERS; j++) begin
            cand = wrap_add(rr_q, j);
            if (!found && consumer_read_valid[cand] && !taken[cand]) begin
              found = 1'b1;
              pick  = cand;
            end
          end
          if (found) begin
            state_d[k]  = WAITING;
            owner_d[k]  = pick;
            addr_d[k]   = consumer_read_address[pick];
            taken[pick] = 1'b1;
            rr_d        = wrap_add(pick, 1);
          end
        end
        WAITING: begin
          if (mem_read_ready[k]) begin
            data_d[owner_q[k]] = mem_read_data[k];
            state_d[k]         = RELAY;
          end
        end
        RELAY: state_d[k] = IDLE;
        default: state_d[k] = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_read_valid      = '0;
    consumer_read_ready = '0;
    busy                = 1'b0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      mem_read_valid[k] = (state_q[k] == WAITING);
      if (state_q[k] == RELAY) consumer_read_ready[owner_q[k]] = 1'b1;
      if (state_q[k] != IDLE) busy = 1'b1;
    end
  end

  assign mem_read_address   = addr_q;
  assign consumer_read_data = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        state_q[k] <= IDLE;
        owner_q[k] <= '0;
      end
      addr_q <= '0;
      data_q <= '0;
      rr_q   <= '0;
    end else begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        state_q[k] <= state_d[k];
        owner_q[k] <= owner_d[k];
      end
      addr_q <= addr_d;
      data_q <= data_d;
      rr_q   <= rr_d;
    end
  end

endmodule

// File: tb/tb_fetch_arbiter.sv
// Bench for fetch_arbiter: vector table, corner sequences, random scoreboard.
// Two instances: 4 consumers on 1 channel, and 4 consumers on 2 channels.
`timescale 1ns/1ps
module tb_fetch_arbiter;

  localparam int NC = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic                   rst1;
  logic [NC-1:0]          vld1;
  logic [NC-1:0][AW-1:0]  adr1;
  logic [NC-1:0]          rdy1;
  logic [NC-1:0][DW-1:0]  dat1;
  logic [0:0]             mv1;
  logic [0:0][AW-1:0]     ma1;
  logic [0:0]             mr1;
  logic [0:0][DW-1:0]     md1;
  logic                   busy1;

  logic                   rst2;
  logic [NC-1:0]          vld2;
  logic [NC-1:0][AW-1:0]  adr2;
  logic [NC-1:0]          rdy2;
  logic [NC-1:0][DW-1:0]  dat2;
  logic [1:0]             mv2;
  logic [1:0][AW-1:0]     ma2;
  logic [1:0]             mr2;
  logic [1:0][DW-1:0]     md2;
  logic                   busy2;

  fetch_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(1),
                  .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_one (
    .clk(clk), .reset(rst1),
    .consumer_read_valid(vld1), .consumer_read_address(adr1),
    .consumer_read_ready(rdy1), .consumer_read_data(dat1),
    .mem_read_valid(mv1), .mem_read_address(ma1),
    .mem_read_ready(mr1), .mem_read_data(md1),
    .busy(busy1)
  );

  fetch_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(2),
                  .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_two (
    .clk(clk), .reset(rst2),
    .consumer_read_valid(vld2), .consumer_read_address(adr2),
    .consumer_read_ready(rdy2), .consumer_read_data(dat2),
    .mem_read_valid(mv2), .mem_read_address(ma2),
    .mem_read_ready(mr2), .mem_read_data(md2),
    .busy(busy2)
  );

  // Memory contents as a pure function of address.
  function automatic logic [31:0] f(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    logic [3:0]  vld;
    logic        mr;
    logic [31:0] md;
    logic        mv;
    logic [7:0]  ma;
    logic [3:0]  cr;
    logic        busy;
    int          dc;
    logic [31:0] dx;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit r, input logic [3:0] v, input logic m,
                     input logic [31:0] d, input logic emv,
                     input logic [7:0] ema, input logic [3:0] ecr,
                     input logic eb, input int dc, input logic [31:0] dx);
    vec_t e;
    e.rst = r; e.vld = v; e.mr = m; e.md = d;
    e.mv = emv; e.ma = ema; e.cr = ecr; e.busy = eb;
    e.dc = dc; e.dx = dx;
    vq.push_back(e);
  endtask

  task automatic step1(input bit r, input logic [3:0] v, input logic m,
                       input logic [31:0] d);
    @(negedge clk);
    rst1 = r; vld1 = v; mr1[0] = m; md1[0] = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input bit r, input logic [3:0] v, input logic [1:0] m,
                       input logic [1:0][31:0] d);
    @(negedge clk);
    rst2 = r; vld2 = v; mr2 = m; md2 = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] ta [4];
  int         pulses;
  int         grants;
  bit         served3;
  logic [3:0] pend;
  logic [7:0] paddr [4];
  int         age [4];
  int         max_age;
  int         dly [2];

  initial begin
    rst1 = 1'b1; vld1 = '0; adr1 = '0; mr1 = '0; md1 = '0;
    rst2 = 1'b1; vld2 = '0; adr2 = '0; mr2 = '0; md2 = '0;

    ta[0] = 8'h20; ta[1] = 8'h21; ta[2] = 8'h10; ta[3] = 8'h23;
    for (int i = 0; i < 4; i++) adr1[i] = ta[i];

    add(1, 4'b0000, 0, 32'h0, 0, 8'h00, 4'b0000, 0, 2, 32'h0);
    add(0, 4'b0100, 0, 32'h0, 1, 8'h10, 4'b0000, 1, -1, 32'h0);
    add(0, 4'b0100, 1, 32'hDEADBEEF, 0, 8'h10, 4'b0100, 1, 2, 32'hDEADBEEF);
    add(0, 4'b0000, 0, 32'h0, 0, 8'h10, 4'b0000, 0, 2, 32'hDEADBEEF);
    add(0, 4'b0000, 1, 32'h0BAD0BAD, 0, 8'h10, 4'b0000, 0, 2, 32'hDEADBEEF);
    add(1, 4'b0000, 0, 32'h0, 0, 8'h00, 4'b0000, 0, 2, 32'h0);
    for (int g = 0; g < 5; g++) begin
      int c;
      c = g % 4;
      add(0, 4'hF, 0, 32'h0, 1, ta[c], 4'b0000, 1, -1, 32'h0);
      add(0, 4'hF, 1, f(ta[c]), 0, ta[c], 4'(1 << c), 1, c, f(ta[c]));
      add(0, 4'hF, 1, 32'h0BAD, 0, ta[c], 4'b0000, 0, c, f(ta[c]));
    end

    for (int i = 0; i < vq.size(); i++) begin
      step1(vq[i].rst, vq[i].vld, vq[i].mr, vq[i].md);
      chk($sformatf("tbl%0d.mv", i), mv1, vq[i].mv);
      chk($sformatf("tbl%0d.ma", i), ma1[0], vq[i].ma);
      chk($sformatf("tbl%0d.cr", i), rdy1, vq[i].cr);
      chk($sformatf("tbl%0d.busy", i), busy1, vq[i].busy);
      if (vq[i].dc >= 0)
        chk($sformatf("tbl%0d.data", i), dat1[vq[i].dc], vq[i].dx);
    end

    // Memory stall with address change and valid drop while waiting.
    step1(1, 4'b0000, 0, 32'h0);
    adr1[0] = 8'h40;
    step1(0, 4'b0001, 0, 32'h0);
    chk("stall.mv0", mv1, 1);
    chk("stall.ma0", ma1[0], 8'h40);
    for (int s = 0; s < 5; s++) begin
      if (s == 2) adr1[0] = 8'h99;
      step1(0, (s >= 3) ? 4'b0000 : 4'b0001, 0, 32'h0);
      chk($sformatf("stall%0d.mv", s), mv1, 1);
      chk($sformatf("stall%0d.ma", s), ma1[0], 8'h40);
      chk($sformatf("stall%0d.busy", s), busy1, 1);
      chk($sformatf("stall%0d.cr", s), rdy1, 4'b0000);
    end
    step1(0, 4'b0000, 1, f(8'h40));
    pulses = rdy1[0] ? 1 : 0;
    chk("stall.cr", rdy1, 4'b0001);
    chk("stall.data", dat1[0], f(8'h40));
    for (int s = 0; s < 4; s++) begin
      step1(0, 4'b0000, 0, 32'h0);
      if (rdy1[0]) pulses++;
    end
    chk("stall.pulses", pulses, 1);

    // Reset while waiting aborts the transaction.
    step1(1, 4'b0000, 0, 32'h0);
    adr1[1] = 8'h21;
    step1(0, 4'b0010, 0, 32'h0);
    chk("rst.mv_pre", mv1, 1);
    step1(1, 4'b0000, 1, f(8'h21));
    chk("rst.mv", mv1, 0);
    chk("rst.ma", ma1[0], 8'h00);
    chk("rst.cr", rdy1, 4'b0000);
    chk("rst.busy", busy1, 0);
    chk("rst.data", dat1[1], 32'h0);
    pulses = 0;
    for (int s = 0; s < 3; s++) begin
      step1(0, 4'b0000, 0, 32'h0);
      if (rdy1 != 4'b0000) pulses++;
    end
    chk("rst.pulses", pulses, 0);
    step1(0, 4'b0010, 0, 32'h0);
    chk("rst.fresh_mv", mv1, 1);
    chk("rst.fresh_ma", ma1[0], 8'h21);
    step1(0, 4'b0010, 1, f(8'h21));
    chk("rst.fresh_cr", rdy1, 4'b0010);
    chk("rst.fresh_data", dat1[1], f(8'h21));
    step1(0, 4'b0000, 0, 32'h0);
    chk("rst.fresh_idle", busy1, 0);

    // Consumer 0 re-requests at once; consumer 3 must still get through.
    step1(1, 4'b0000, 0, 32'h0);
    adr1[0] = 8'h30; adr1[3] = 8'h33;
    grants = 0; served3 = 1'b0;
    for (int i = 0; i < 40 && !served3; i++) begin
      step1(0, 4'b1001, mv1[0], f(ma1[0]));
      if (rdy1[0]) grants++;
      if (rdy1[3]) begin
        grants++;
        served3 = 1'b1;
      end
    end
    chk("starve.served", served3, 1);
    chk("starve.bound", (grants <= 4), 1);

    // Two channels, two simultaneous requesters.
    for (int i = 0; i < 4; i++) adr2[i] = 8'(8'h50 + i);
    step2(1, 4'b0000, 2'b00, '0);
    chk("dual.reset_busy", busy2, 0);
    step2(0, 4'b1010, 2'b00, '0);
    chk("dual.mv", mv2, 2'b11);
    chk("dual.ma0", ma2[0], 8'h51);
    chk("dual.ma1", ma2[1], 8'h53);
    step2(0, 4'b1010, 2'b11, {f(8'h53), f(8'h51)});
    chk("dual.cr", rdy2, 4'b1010);
    chk("dual.d1", dat2[1], f(8'h51));
    chk("dual.d3", dat2[3], f(8'h53));
    step2(0, 4'b0000, 2'b00, '0);
    chk("dual.idle", busy2, 0);
    step2(0, 4'b1111, 2'b00, '0);
    chk("dual.ptr_ma0", ma2[0], 8'h50);
    chk("dual.ptr_ma1", ma2[1], 8'h51);

    // Random traffic on two channels against a pending-request scoreboard.
    step2(1, 4'b0000, 2'b00, '0);
    rst2 = 1'b0;
    pend = '0; max_age = 0;
    for (int i = 0; i < 4; i++) begin
      age[i] = 0;
      paddr[i] = '0;
    end
    dly[0] = 0; dly[1] = 0;
    for (int cyc = 0; cyc < 3060; cyc++) begin
      @(negedge clk);
      chk("rnd.busy", busy2, (|mv2) | (|rdy2));
      for (int i = 0; i < 4; i++) begin
        if (rdy2[i]) begin
          chk($sformatf("rnd.owner%0d", i), pend[i], 1);
          chk($sformatf("rnd.data%0d", i), dat2[i], f(paddr[i]));
          pend[i] = 1'b0;
          vld2[i] = 1'b0;
        end else if (pend[i]) begin
          age[i]++;
          if (age[i] > max_age) max_age = age[i];
        end else if (cyc < 3000 && ($urandom % 3) == 0) begin
          pend[i]  = 1'b1;
          paddr[i] = 8'($urandom);
          adr2[i]  = paddr[i];
          vld2[i]  = 1'b1;
          age[i]   = 0;
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (mv2[k]) begin
          if (dly[k] == 0) begin
            mr2[k] = 1'b1;
            md2[k] = f(ma2[k]);
            dly[k] = int'($urandom % 4);
          end else begin
            mr2[k] = 1'b0;
            dly[k]--;
          end
        end else begin
          mr2[k] = (($urandom % 4) == 0);
          md2[k] = $urandom;
        end
      end
    end
    chk("rnd.drained", pend, 4'b0000);
    chk("rnd.max_age", (max_age <= 40), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
